// File: rtl/bus_arbiter_rr4.sv
// Round-robin 4:1 bus arbiter: 1-clock req->gnt, per-owner hold limit, 1-cycle turnaround gap between owners.
// Define ARB_LOCK_EN to let lock[owner] extend a grant past MAX_HOLD; otherwise lock is ignored.
module bus_arbiter_rr4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] lock,
  output logic [3:0] gnt,
  output logic       mux_en,
  output logic       mux_s0,
  output logic       mux_s1,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [1:0]       r_last_ptr;
  logic [1:0]       r_owner;
  logic [3:0]       r_gnt;
  logic             r_mux_en;
  logic             r_busy;
  logic             r_timeout;

  logic [2:0]       w_pick;
  logic             w_owner_req;
  logic             w_hold_lim;
  logic             w_lock_hold;

  // Returns {valid, index}; scanning from the farthest slot back lets the nearest one win.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] c;
    rr_pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      c = last + 2'(k);
      if (r[c]) rr_pick = {1'b1, c};
    end
  endfunction

  assign w_pick      = rr_pick(req, r_last_ptr);
  assign w_owner_req = req[r_owner];
  assign w_hold_lim  = (r_hold_cnt == HOLD_LIM);

`ifdef ARB_LOCK_EN
  assign w_lock_hold = lock[r_owner] & w_owner_req;
`else
  logic w_unused_lock;
  assign w_unused_lock = ^lock;
  assign w_lock_hold   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_last_ptr <= 2'd3;
      r_owner    <= 2'd0;
      r_gnt      <= 4'b0000;
      r_mux_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_pick[2]) begin
            r_state    <= S_GRANT;
            r_owner    <= w_pick[1:0];
            r_gnt      <= 4'b0001 << w_pick[1:0];
            r_mux_en   <= 1'b1;
            r_busy     <= 1'b1;
            r_hold_cnt <= '0;
          end else begin
            r_state  <= S_IDLE;
            r_gnt    <= 4'b0000;
            r_mux_en <= 1'b0;
            r_busy   <= 1'b0;
          end
        end
        S_GRANT: begin
          // Release takes precedence over a timeout on the same cycle.
          if (!w_owner_req || (w_hold_lim && !w_lock_hold)) begin
            r_state    <= S_GAP;
            r_last_ptr <= r_owner;
            r_gnt      <= 4'b0000;
            r_mux_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= w_owner_req;
          end else if (!w_hold_lim) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_gnt    <= 4'b0000;
          r_mux_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign mux_en  = r_mux_en;
  assign mux_s0  = r_owner[1];
  assign mux_s1  = r_owner[0];
  assign busy    = r_busy;
  assign timeout = r_timeout;

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_mux_en: assert property (@(posedge clk) disable iff (!rst_n) mux_en == (|gnt));
  a_gap:    assert property (@(posedge clk) disable iff (!rst_n)
                             ((|gnt) && (|$past(gnt))) |-> (gnt == $past(gnt)));

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Scoreboarded bench for bus_arbiter_rr4: a spec-level model predicts each cycle's outputs.
module tb_bus_arbiter_rr4;

  localparam int MH = 8;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] lock = 4'b0000;
  logic [3:0] gnt;
  logic       mux_en, mux_s0, mux_s1, busy, timeout;

  bus_arbiter_rr4 #(.MAX_HOLD(MH), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .gnt(gnt),
    .mux_en(mux_en), .mux_s0(mux_s0), .mux_s1(mux_s1), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] sb_q[$];
  logic [3:0] prev_gnt = 4'b0000;

  // Model state: 0 idle, 1 grant, 2 gap; m_len counts cycles owned including the current one.
  int m_st, m_owner, m_last, m_len;
  bit m_to;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_owner = 0; m_last = 3; m_len = 0; m_to = 1'b0;
    sb_q.delete();
    prev_gnt = 4'b0000;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] l);
    int found;
    m_to = 1'b0;
    if (m_st == 1) begin
      if (!r[m_owner]) begin
        m_st = 2; m_last = m_owner;
      end else if (m_len >= MH && !(LOCK_EN && l[m_owner])) begin
        m_st = 2; m_last = m_owner; m_to = 1'b1;
      end else begin
        m_len++;
      end
    end else begin
      found = -1;
      for (int k = 1; k <= 4; k++)
        if (found < 0 && r[(m_last + k) % 4]) found = (m_last + k) % 4;
      if (found >= 0) begin
        m_st = 1; m_owner = found; m_len = 1;
      end else begin
        m_st = 0;
      end
    end
  endtask

  function automatic logic [8:0] model_out();
    logic [3:0] g;
    logic [1:0] o;
    g = (m_st == 1) ? (4'b0001 << m_owner) : 4'b0000;
    o = 2'(m_owner);
    return {g, (m_st == 1), o[1], o[0], (m_st == 1), m_to};
  endfunction

  task automatic step(input logic [3:0] r, input logic [3:0] l);
    logic [8:0] exp;
    req = r;
    lock = l;
    model_step(r, l);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    chk("outs", 16'({gnt, mux_en, mux_s0, mux_s1, busy, timeout}), 16'(exp));
    chk("onehot", 16'($onehot0(gnt)), 16'd1);
    chk("en_eq_gnt", 16'(mux_en), 16'(|gnt));
    if (prev_gnt != 4'b0000 && gnt != 4'b0000) chk("gap", 16'(gnt), 16'(prev_gnt));
    prev_gnt = gnt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    lock = 4'b0000;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_outs", 16'({gnt, mux_en, mux_s0, mux_s1, busy, timeout}), 16'd0);
    rst_n = 1'b1;
  endtask

  int tcount, gcount;
  logic [3:0] rr;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Full contention: rotate 0,1,2,3,0 with 8-cycle grants and 1-cycle gaps.
    for (int s = 1; s <= 45; s++) begin
      step(4'b1111, 4'b0000);
      if (s % 9 == 1) chk("rr_gnt", 16'(gnt), 16'(4'b0001 << (((s - 1) / 9) % 4)));
      if (s % 9 == 0) chk("rr_gap", 16'(gnt), 16'd0);
    end

    // Single-cycle request.
    do_reset();
    step(4'b0100, 4'b0000);
    chk("one_gnt", 16'({gnt, mux_en, mux_s0, mux_s1}), 16'({4'b0100, 1'b1, 1'b1, 1'b0}));
    step(4'b0000, 4'b0000);
    chk("one_gap", 16'({gnt, mux_en, mux_s0, mux_s1}), 16'({4'b0000, 1'b0, 1'b1, 1'b0}));
    step(4'b0000, 4'b0000);
    chk("one_idle", 16'({busy, mux_en}), 16'd0);

    // Lone requester: timeout, gap, re-grant.
    do_reset();
    tcount = 0; gcount = 0;
    for (int s = 1; s <= 20; s++) begin
      step(4'b0100, 4'b0000);
      if (gnt == 4'b0100) gcount++;
      if (timeout) tcount++;
    end
    chk("lone_gcnt", 16'(gcount), 16'd18);
    chk("lone_tcnt", 16'(tcount), 16'd2);

    // Release coincident with the hold limit counts as a release.
    do_reset();
    for (int s = 1; s <= 8; s++) step(4'b0100, 4'b0000);
    step(4'b0000, 4'b0000);
    chk("rel_vs_to", 16'({gnt, timeout}), 16'd0);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    for (int s = 1; s <= 3; s++) step(4'b0010, 4'b0000);
    chk("pre_rst_gnt", 16'(gnt), 16'(4'b0010));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 16'({gnt, mux_en, busy}), 16'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold", 16'({gnt, mux_en}), 16'd0);
    rst_n = 1'b1;
    step(4'b1111, 4'b0000);
    chk("post_rst", 16'(gnt), 16'(4'b0001));

    // Lock on the owner.
    do_reset();
`ifdef ARB_LOCK_EN
    tcount = 0; gcount = 0;
    for (int s = 1; s <= 20; s++) begin
      step(4'b0011, 4'b0001);
      if (gnt == 4'b0001) gcount++;
      if (timeout) tcount++;
    end
    chk("lock_gcnt", 16'(gcount), 16'd20);
    chk("lock_tcnt", 16'(tcount), 16'd0);
    step(4'b0011, 4'b0000);
    chk("lock_drop", 16'({gnt, timeout}), 16'({4'b0000, 1'b1}));
    step(4'b0011, 4'b0000);
    chk("lock_next", 16'(gnt), 16'(4'b0010));
`else
    for (int s = 1; s <= 8; s++) step(4'b0011, 4'b0001);
    step(4'b0011, 4'b0001);
    chk("nolock_to", 16'({gnt, timeout}), 16'({4'b0000, 1'b1}));
    step(4'b0011, 4'b0001);
    chk("nolock_next", 16'(gnt), 16'(4'b0010));
`endif

    // Random traffic with sticky requests.
    do_reset();
    rr = 4'b0000;
    for (int s = 0; s < 3000; s++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      step(rr, 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
